// File: rtl/pc_gen_if.sv
// pc_gen_if: redirect inputs and fetch-address outputs of the PC generator.
// master = pc_gen side (drives pc_o/pc_valid_o/pend_o/misalign_o),
// slave  = pipeline side (drives stall, exception, branch, jump, call, ret).
interface pc_gen_if #(
    parameter int PC_W = 32
);
    logic            stall_i;
    logic            exc_i;
    logic            br_taken_i;
    logic [PC_W-1:0] br_target_i;
    logic            jmp_i;
    logic [PC_W-1:0] jmp_target_i;
    logic            call_i;
    logic            ret_i;
    logic [PC_W-1:0] pc_o;
    logic            pc_valid_o;
    logic            pend_o;
    logic            misalign_o;

    modport master (
        input  stall_i, exc_i,
        input  br_taken_i, br_target_i,
        input  jmp_i, jmp_target_i,
        input  call_i, ret_i,
        output pc_o, pc_valid_o,
        output pend_o, misalign_o
    );

    modport slave (
        output stall_i, exc_i,
        output br_taken_i, br_target_i,
        output jmp_i, jmp_target_i,
        output call_i, ret_i,
        input  pc_o, pc_valid_o,
        input  pend_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with boot cycle, prioritised redirects,
// stall-tolerant pending redirect, misaligned-target detection.
// Ports: clk_i, rst_i (async, active-low), bus (pc_gen_if.master).
// Optional return-address stack enabled by defining macro PC_RAS_EN.
module pc_gen #(
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_VEC   = '0,
    parameter logic [PC_W-1:0] EXC_VEC     = PC_W'(32'h80),
    parameter int              INSTR_BYTES = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pc_gen_if.master bus
);
    localparam logic [PC_W-1:0] STEP = PC_W'(INSTR_BYTES);
    localparam logic [PC_W-1:0] LOW_MASK = PC_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;
    logic            pend_q;
    logic            pend_br_q;
    logic [PC_W-1:0] tgt_q;
    logic            mis_q;

    logic            run_go;
    logic            pop;
    logic            push;
    logic            ras_nonempty;
    logic [PC_W-1:0] ras_top;

    function automatic logic [PC_W-1:0] align(
        input logic [PC_W-1:0] a
    );
        return a & ~LOW_MASK;
    endfunction

    function automatic logic is_mis(
        input logic [PC_W-1:0] a
    );
        return |(a & LOW_MASK);
    endfunction

    // A return is taken only when nothing of higher priority redirects.
    always_comb begin
        run_go = (state_q != BOOT) && !bus.stall_i;
        push   = run_go && bus.call_i;
        pop    = run_go && bus.ret_i && ras_nonempty
                 && !bus.exc_i && !pend_q
                 && !bus.br_taken_i && !bus.jmp_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= BOOT;
            pc_q      <= RESET_VEC;
            valid_q   <= 1'b0;
            pend_q    <= 1'b0;
            pend_br_q <= 1'b0;
            tgt_q     <= '0;
            mis_q     <= 1'b0;
        end else begin
            mis_q <= 1'b0;
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN, HOLD: begin
                    state_q <= bus.stall_i ? HOLD : RUN;
                    if (bus.exc_i) begin
                        pc_q   <= EXC_VEC;
                        pend_q <= 1'b0;
                    end else if (!bus.stall_i) begin
                        if (pend_q) begin
                            pc_q   <= tgt_q;
                            pend_q <= 1'b0;
                        end else if (bus.br_taken_i) begin
                            pc_q  <= align(bus.br_target_i);
                            mis_q <= is_mis(bus.br_target_i);
                        end else if (bus.jmp_i) begin
                            pc_q  <= align(bus.jmp_target_i);
                            mis_q <= is_mis(bus.jmp_target_i);
                        end else if (pop) begin
                            pc_q <= ras_top;
                        end else begin
                            pc_q <= pc_q + STEP;
                        end
                    end else if (bus.br_taken_i) begin
                        // Branch outranks any latched jump.
                        pend_q    <= 1'b1;
                        pend_br_q <= 1'b1;
                        tgt_q     <= align(bus.br_target_i);
                        mis_q     <= is_mis(bus.br_target_i);
                    end else if (bus.jmp_i
                                 && !(pend_q && pend_br_q)) begin
                        pend_q    <= 1'b1;
                        pend_br_q <= 1'b0;
                        tgt_q     <= align(bus.jmp_target_i);
                        mis_q     <= is_mis(bus.jmp_target_i);
                    end
                end
                default: begin
                    state_q <= BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_RAS_EN
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [IW-1:0]   wp_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   top_idx;

    // wp_q is the next write slot; the top entry sits just below it.
    always_comb begin
        top_idx = (wp_q == '0) ? IW'(RAS_DEPTH - 1)
                               : wp_q - IW'(1);
        ras_nonempty = (cnt_q != '0);
        ras_top      = ras_q[top_idx];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wp_q  <= '0;
            cnt_q <= '0;
        end else if (pop && !push) begin
            wp_q  <= top_idx;
            cnt_q <= cnt_q - CW'(1);
        end else if (push && !pop) begin
            wp_q  <= (wp_q == IW'(RAS_DEPTH - 1))
                     ? '0 : wp_q + IW'(1);
            if (cnt_q != CW'(RAS_DEPTH))
                cnt_q <= cnt_q + CW'(1);
        end
    end

    // Pop+push reuses the popped slot, so depth stays the same.
    always_ff @(posedge clk_i) begin
        if (push)
            ras_q[pop ? top_idx : wp_q] <= pc_q + STEP;
    end
`else
    logic unused_ras;

    assign ras_nonempty = 1'b0;
    assign ras_top      = '0;
    assign unused_ras   = bus.call_i ^ bus.ret_i ^ push;
`endif

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = valid_q;
    assign bus.pend_o     = pend_q;
    assign bus.misalign_o = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus random stimulus for pc_gen (PC_W=8),
// checked against a queue-based behavioural model.
module tb_pc_gen;
    localparam int         W   = 8;
    localparam logic [7:0] EXC = 8'h80;
    localparam int         D   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_gen_if #(.PC_W(W)) bus ();

    pc_gen #(
        .PC_W(W),
        .RESET_VEC(8'h00),
        .EXC_VEC(EXC),
        .INSTR_BYTES(4),
        .RAS_DEPTH(D)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic       m_valid;
    logic       m_pend;
    logic [7:0] m_tgt;
    int         m_rank;
    logic       m_mis;
    logic       m_boot;
    logic [7:0] ras[$];

    logic       in_stall, in_exc, in_br, in_jmp;
    logic       in_call, in_ret;
    logic [7:0] in_bt, in_jt;

    task automatic model_reset();
        m_pc = 8'h00;
        m_valid = 1'b0;
        m_pend = 1'b0;
        m_tgt = 8'h00;
        m_rank = 0;
        m_mis = 1'b0;
        m_boot = 1'b1;
        ras.delete();
    endtask

    task automatic model_step();
        logic [7:0] old;
        old = m_pc;
        m_mis = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
            m_valid = 1'b1;
        end else if (in_exc) begin
            m_pc = EXC;
            m_pend = 1'b0;
        end else if (!in_stall) begin
            if (m_pend) begin
                m_pc = m_tgt;
                m_pend = 1'b0;
            end else if (in_br) begin
                m_pc = {in_bt[7:2], 2'b00};
                m_mis = (in_bt % 4) != 0;
            end else if (in_jmp) begin
                m_pc = {in_jt[7:2], 2'b00};
                m_mis = (in_jt % 4) != 0;
            end
`ifdef PC_RAS_EN
            else if (in_ret && ras.size() > 0) begin
                m_pc = ras.pop_back();
            end
`endif
            else begin
                m_pc = old + 8'd4;
            end
        end else begin
            if (in_br) begin
                m_pend = 1'b1;
                m_rank = 2;
                m_tgt = {in_bt[7:2], 2'b00};
                m_mis = (in_bt % 4) != 0;
            end else if (in_jmp && !(m_pend && m_rank == 2)) begin
                m_pend = 1'b1;
                m_rank = 1;
                m_tgt = {in_jt[7:2], 2'b00};
                m_mis = (in_jt % 4) != 0;
            end
        end
`ifdef PC_RAS_EN
        if (!m_boot && !in_stall && in_call && m_valid
            && old == old) begin
            ras.push_back(old + 8'd4);
            if (ras.size() > D)
                void'(ras.pop_front());
        end
`endif
    endtask

    task automatic check(input string tag);
        n_chk++;
        assert (bus.pc_o === m_pc) else begin
            n_fail++;
            $error("FAIL %s pc got %h exp %h", tag, bus.pc_o, m_pc);
        end
        n_chk++;
        assert (bus.pc_valid_o === m_valid) else begin
            n_fail++;
            $error("FAIL %s valid got %b exp %b",
                   tag, bus.pc_valid_o, m_valid);
        end
        n_chk++;
        assert (bus.pend_o === m_pend) else begin
            n_fail++;
            $error("FAIL %s pend got %b exp %b",
                   tag, bus.pend_o, m_pend);
        end
        n_chk++;
        assert (bus.misalign_o === m_mis) else begin
            n_fail++;
            $error("FAIL %s misalign got %b exp %b",
                   tag, bus.misalign_o, m_mis);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [7:0] exp);
        n_chk++;
        assert (bus.pc_o === exp) else begin
            n_fail++;
            $error("FAIL %s pc got %h exp %h", tag, bus.pc_o, exp);
        end
    endtask

    task automatic cyc(
        input string      tag,
        input logic       st,
        input logic       ex,
        input logic       br,
        input logic [7:0] bt,
        input logic       jm,
        input logic [7:0] jt,
        input logic       ca,
        input logic       re
    );
        in_stall = st; in_exc = ex;
        in_br = br; in_bt = bt;
        in_jmp = jm; in_jt = jt;
        in_call = ca; in_ret = re;
        bus.stall_i = st;
        bus.exc_i = ex;
        bus.br_taken_i = br;
        bus.br_target_i = bt;
        bus.jmp_i = jm;
        bus.jmp_target_i = jt;
        bus.call_i = ca;
        bus.ret_i = re;
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        bus.stall_i = 0; bus.exc_i = 0;
        bus.br_taken_i = 0; bus.br_target_i = '0;
        bus.jmp_i = 0; bus.jmp_target_i = '0;
        bus.call_i = 0; bus.ret_i = 0;
        model_reset();
        #12;
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot");

        idle("boot_edge");
        chk_pc("boot_pc", 8'h00);
        idle("seq1");
        idle("seq2");
        idle("seq3");
        chk_pc("seq_12", 8'h0C);

        cyc("jmp_fc", 0, 0, 0, 8'h00, 1, 8'hFC, 0, 0);
        idle("wrap");
        chk_pc("wrap_0", 8'h00);

        cyc("to_10", 0, 0, 0, 8'h00, 1, 8'h10, 0, 0);
        cyc("st_br", 1, 0, 1, 8'h40, 0, 8'h00, 0, 0);
        cyc("st_jmp", 1, 0, 0, 8'h00, 1, 8'h80, 0, 0);
        chk_pc("held_10", 8'h10);
        idle("release");
        chk_pc("pend_40", 8'h40);

        cyc("st_br2", 1, 0, 1, 8'h40, 0, 8'h00, 0, 0);
        cyc("st_exc", 1, 1, 0, 8'h00, 0, 8'h00, 0, 0);
        chk_pc("exc_80", 8'h80);
        idle("exc_rel");
        chk_pc("exc_84", 8'h84);

        cyc("mis_br", 0, 0, 1, 8'h23, 0, 8'h00, 0, 0);
        chk_pc("mis_20", 8'h20);
        idle("mis_off");

        cyc("r_10", 0, 0, 0, 8'h00, 1, 8'h10, 0, 0);
        cyc("call1", 0, 0, 0, 8'h00, 1, 8'h20, 1, 0);
        cyc("call2", 0, 0, 0, 8'h00, 1, 8'h30, 1, 0);
        cyc("call3", 0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        cyc("ret1", 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
`ifdef PC_RAS_EN
        chk_pc("ret_34", 8'h34);
`endif
        cyc("ret2", 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
`ifdef PC_RAS_EN
        chk_pc("ret_24", 8'h24);
`endif
        cyc("ret3", 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
`ifdef PC_RAS_EN
        chk_pc("ret_seq", 8'h28);
`endif

        for (int i = 0; i < 400; i++) begin
            cyc("rand",
                $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 4,
                $urandom_range(0, 99) < 15,
                8'($urandom),
                $urandom_range(0, 99) < 12,
                8'($urandom),
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 15);
        end

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst");
        bus.stall_i = 0; bus.exc_i = 0;
        bus.br_taken_i = 0; bus.jmp_i = 0;
        bus.call_i = 0; bus.ret_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle("reboot");
        idle("reboot_seq");
        chk_pc("reboot_4", 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
